// File: rtl/btb_pkg.sv
// Shared definitions for the branch target buffer: prediction encodings,
// FSM states and PC field extraction helpers.
package btb_pkg;

   localparam logic [1:0] SNT = 2'b00;
   localparam logic [1:0] WNT = 2'b01;
   localparam logic [1:0] WT  = 2'b10;
   localparam logic [1:0] ST  = 2'b11;

   localparam logic [1:0] MISS_CTR = WNT;

   localparam int MAX_PC_W = 64;

   typedef enum logic {IDLE, SWEEP} btb_state_e;

   // Word index: bits [idx_w+1:2]; caller narrows the result to idx_w bits.
   function automatic logic [MAX_PC_W-1:0] btb_index(input logic [MAX_PC_W-1:0] pc,
                                                    input int idx_w);
      logic [MAX_PC_W-1:0] mask;
      mask = (MAX_PC_W'(1) << idx_w) - MAX_PC_W'(1);
      return (pc >> 2) & mask;
   endfunction

   // Tag: everything above the index field; caller narrows to the tag width.
   function automatic logic [MAX_PC_W-1:0] btb_tag(input logic [MAX_PC_W-1:0] pc,
                                                  input int idx_w);
      return pc >> (idx_w + 2);
   endfunction

endpackage

// File: rtl/btb_entry_array.sv
// BTB storage: tag/target/counter arrays (not reset) with one async read and
// one write port, plus a valid vector with async reset and a per-index clear.
module btb_entry_array
   import btb_pkg::*;
#(
   parameter int ENTRIES = 16,
   parameter int IDX_W   = 4,
   parameter int TAG_W   = 26,
   parameter int PC_W    = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [IDX_W-1:0] rd_idx,
   output logic             rd_valid,
   output logic [TAG_W-1:0] rd_tag,
   output logic [PC_W-1:0]  rd_target,
   output logic [1:0]       rd_ctr,
   input  logic             wr_en,
   input  logic [IDX_W-1:0] wr_idx,
   input  logic [TAG_W-1:0] wr_tag,
   input  logic [PC_W-1:0]  wr_target,
   input  logic [1:0]       wr_ctr,
   input  logic             clr_en,
   input  logic [IDX_W-1:0] clr_idx
);

   logic [TAG_W-1:0] tag_mem    [ENTRIES];
   logic [PC_W-1:0]  target_mem [ENTRIES];
   logic [1:0]       ctr_mem    [ENTRIES];
   logic [ENTRIES-1:0] valid_q;

   always_ff @(posedge clk) begin
      if (wr_en) begin
         tag_mem[wr_idx]    <= wr_tag;
         target_mem[wr_idx] <= wr_target;
         ctr_mem[wr_idx]    <= wr_ctr;
      end
   end

   // Write and clear never target the same cycle: writes are only accepted
   // outside a sweep, clears only happen during one.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_q <= '0;
      end else begin
         if (wr_en)
            valid_q[wr_idx] <= 1'b1;
         if (clr_en)
            valid_q[clr_idx] <= 1'b0;
      end
   end

   assign rd_valid  = valid_q[rd_idx];
   assign rd_tag    = tag_mem[rd_idx];
   assign rd_target = target_mem[rd_idx];
   assign rd_ctr    = ctr_mem[rd_idx];

endmodule

// File: rtl/branch_target_buffer.sv
// Direct-mapped branch target buffer for the IF stage: zero-latency lookup,
// update from the branch unit with same-cycle bypass, and invalidate sweep.
module branch_target_buffer
   import btb_pkg::*;
#(
   parameter int ENTRIES = 16,
   parameter int PC_W    = 32
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic [PC_W-1:0] i_PC,
   output logic            o_PcMatchValid,
   output logic [1:0]      o_CtrlOut,
   output logic            o_PredTaken,
   output logic [PC_W-1:0] o_PredTarget,
   input  logic            i_WriteEnable,
   input  logic [PC_W-1:0] i_UpdPC,
   input  logic [PC_W-1:0] i_UpdTarget,
   input  logic [1:0]      i_UpdCtrl,
   input  logic            i_Invalidate,
   output logic            o_Busy
);

   localparam int IDX_W = $clog2(ENTRIES);
   localparam int TAG_W = PC_W - IDX_W - 2;

   btb_state_e       state;
   logic [IDX_W-1:0] cnt;

   logic [MAX_PC_W-1:0] lk_pc_ext, upd_pc_ext;
   logic [IDX_W-1:0]    lk_idx, upd_idx;
   logic [TAG_W-1:0]    lk_tag, upd_tag;

   logic             arr_valid;
   logic [TAG_W-1:0] arr_tag;
   logic [PC_W-1:0]  arr_target;
   logic [1:0]       arr_ctr;

   logic             upd_accept, bypass, hit;
   logic             sel_valid;
   logic [TAG_W-1:0] sel_tag;
   logic [PC_W-1:0]  sel_target;
   logic [1:0]       sel_ctr;

   assign lk_pc_ext  = MAX_PC_W'(i_PC);
   assign upd_pc_ext = MAX_PC_W'(i_UpdPC);
   assign lk_idx     = IDX_W'(btb_index(lk_pc_ext, IDX_W));
   assign lk_tag     = TAG_W'(btb_tag(lk_pc_ext, IDX_W));
   assign upd_idx    = IDX_W'(btb_index(upd_pc_ext, IDX_W));
   assign upd_tag    = TAG_W'(btb_tag(upd_pc_ext, IDX_W));

   assign o_Busy     = (state == SWEEP);
   assign upd_accept = i_WriteEnable & (state == IDLE) & ~i_Invalidate;

   btb_entry_array #(
      .ENTRIES (ENTRIES),
      .IDX_W   (IDX_W),
      .TAG_W   (TAG_W),
      .PC_W    (PC_W)
   ) u_array (
      .clk       (clk),
      .rst_n     (rst_n),
      .rd_idx    (lk_idx),
      .rd_valid  (arr_valid),
      .rd_tag    (arr_tag),
      .rd_target (arr_target),
      .rd_ctr    (arr_ctr),
      .wr_en     (upd_accept),
      .wr_idx    (upd_idx),
      .wr_tag    (upd_tag),
      .wr_target (i_UpdTarget),
      .wr_ctr    (i_UpdCtrl),
      .clr_en    (o_Busy),
      .clr_idx   (cnt)
   );

   // An update landing on the looked-up index this cycle is forwarded so the
   // fetch sees the freshest prediction without waiting for the write.
   assign bypass     = upd_accept & (upd_idx == lk_idx);
   assign sel_valid  = bypass ? 1'b1        : arr_valid;
   assign sel_tag    = bypass ? upd_tag     : arr_tag;
   assign sel_target = bypass ? i_UpdTarget : arr_target;
   assign sel_ctr    = bypass ? i_UpdCtrl   : arr_ctr;

   assign hit            = sel_valid & (sel_tag == lk_tag) & ~o_Busy;
   assign o_PcMatchValid = hit;
   assign o_CtrlOut      = hit ? sel_ctr : MISS_CTR;
   assign o_PredTaken    = hit & sel_ctr[1];
   assign o_PredTarget   = hit ? sel_target : '0;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         cnt   <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (i_Invalidate) begin
                  state <= SWEEP;
                  cnt   <= '0;
               end
            end
            SWEEP: begin
               if (cnt == IDX_W'(ENTRIES - 1)) begin
                  state <= IDLE;
                  cnt   <= '0;
               end else begin
                  cnt <= cnt + IDX_W'(1);
               end
            end
            default: begin
               state <= IDLE;
               cnt   <= '0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_branch_target_buffer.sv
// Self-checking bench for branch_target_buffer: directed plan plus random
// traffic compared against an abstract reference model.
module tb_branch_target_buffer;

   localparam int ENTRIES = 16;
   localparam int PC_W    = 32;

   logic            clk = 1'b0;
   logic            rst_n;
   logic [PC_W-1:0] i_PC;
   logic            o_PcMatchValid;
   logic [1:0]      o_CtrlOut;
   logic            o_PredTaken;
   logic [PC_W-1:0] o_PredTarget;
   logic            i_WriteEnable;
   logic [PC_W-1:0] i_UpdPC;
   logic [PC_W-1:0] i_UpdTarget;
   logic [1:0]      i_UpdCtrl;
   logic            i_Invalidate;
   logic            o_Busy;

   int total = 0;
   int bad   = 0;

   // Reference model: one record per slot, keyed by word address modulo ENTRIES.
   bit          m_valid  [ENTRIES];
   int unsigned m_tag    [ENTRIES];
   logic [31:0] m_target [ENTRIES];
   logic [1:0]  m_ctr    [ENTRIES];
   int          busy_left;

   branch_target_buffer #(.ENTRIES(ENTRIES), .PC_W(PC_W)) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .i_PC           (i_PC),
      .o_PcMatchValid (o_PcMatchValid),
      .o_CtrlOut      (o_CtrlOut),
      .o_PredTaken    (o_PredTaken),
      .o_PredTarget   (o_PredTarget),
      .i_WriteEnable  (i_WriteEnable),
      .i_UpdPC        (i_UpdPC),
      .i_UpdTarget    (i_UpdTarget),
      .i_UpdCtrl      (i_UpdCtrl),
      .i_Invalidate   (i_Invalidate),
      .o_Busy         (o_Busy)
   );

   always #5 clk = ~clk;

   function automatic int unsigned slot_of(input logic [31:0] pc);
      return (pc / 4) % ENTRIES;
   endfunction

   function automatic int unsigned tag_of(input logic [31:0] pc);
      return pc / (4 * ENTRIES);
   endfunction

   task automatic model_reset();
      for (int i = 0; i < ENTRIES; i++) m_valid[i] = 1'b0;
      busy_left = 0;
   endtask

   // Expected outputs {hit, ctr, taken, target, busy} for the current inputs.
   function automatic logic [36:0] expected();
      bit          h;
      logic [1:0]  c;
      logic [31:0] t;
      int unsigned s;
      h = 1'b0; c = 2'b01; t = '0;
      if (rst_n === 1'b1 && busy_left == 0) begin
         s = slot_of(i_PC);
         if (i_WriteEnable && !i_Invalidate && slot_of(i_UpdPC) == s) begin
            if (tag_of(i_UpdPC) == tag_of(i_PC)) begin
               h = 1'b1; c = i_UpdCtrl; t = i_UpdTarget;
            end
         end else if (m_valid[s] && m_tag[s] == tag_of(i_PC)) begin
            h = 1'b1; c = m_ctr[s]; t = m_target[s];
         end
      end
      return {h, c, h & c[1], t, (rst_n === 1'b1) && (busy_left > 0)};
   endfunction

   task automatic check(input string name);
      logic [36:0] obs, exp_v;
      #1;
      exp_v = expected();
      obs   = {o_PcMatchValid, o_CtrlOut, o_PredTaken, o_PredTarget, o_Busy};
      total++;
      assert (obs === exp_v) else begin
         bad++;
         $error("FAIL %s pc=%h observed=%h expected=%h", name, i_PC, obs, exp_v);
      end
   endtask

   // One clock edge; the model follows the abstract rules, then inputs may be
   // changed after the falling edge.
   task automatic cycle();
      int unsigned s;
      @(posedge clk);
      if (busy_left > 0) begin
         busy_left--;
      end else if (i_Invalidate) begin
         for (int i = 0; i < ENTRIES; i++) m_valid[i] = 1'b0;
         busy_left = ENTRIES;
      end else if (i_WriteEnable) begin
         s = slot_of(i_UpdPC);
         m_valid[s]  = 1'b1;
         m_tag[s]    = tag_of(i_UpdPC);
         m_target[s] = i_UpdTarget;
         m_ctr[s]    = i_UpdCtrl;
      end
      @(negedge clk);
   endtask

   task automatic upd(input logic [31:0] pc, input logic [31:0] tgt, input logic [1:0] c);
      i_WriteEnable = 1'b1; i_UpdPC = pc; i_UpdTarget = tgt; i_UpdCtrl = c;
   endtask

   task automatic idle_inputs();
      i_WriteEnable = 1'b0; i_Invalidate = 1'b0;
   endtask

   initial begin
      logic [31:0] pc;
      rst_n = 1'b0; i_PC = 32'h40; i_UpdPC = '0; i_UpdTarget = '0; i_UpdCtrl = '0;
      idle_inputs();
      model_reset();
      check("reset_lookup");
      @(negedge clk); @(negedge clk);
      rst_n = 1'b1;
      check("after_reset");

      upd(32'h40, 32'h100, 2'b11); i_PC = 32'h0;
      check("write_0x40");
      cycle(); idle_inputs(); i_PC = 32'h40;
      check("hit_0x40");

      i_PC = 32'h80;
      check("alias_miss_0x80");
      upd(32'h80, 32'h300, 2'b10); i_PC = 32'h0;
      cycle(); idle_inputs();
      i_PC = 32'h80; check("alias_hit_0x80");
      i_PC = 32'h40; check("evicted_0x40");

      upd(32'h44, 32'h200, 2'b10); i_PC = 32'h44;
      check("bypass_0x44");
      cycle(); idle_inputs();
      check("stored_0x44");

      for (int i = 0; i < ENTRIES; i++) begin
         upd(32'h1000 + 32'(i * 4), $urandom, 2'($urandom));
         i_PC = 32'h1000 + 32'(i * 4);
         check("fill_bypass");
         cycle();
      end
      idle_inputs();
      for (int i = 0; i < ENTRIES; i++) begin
         i_PC = 32'h1000 + 32'(i * 4); check("fill_hit");
      end

      // Sweep: re-invalidate at cycle 5 and write at cycle 8 must both be dropped.
      i_Invalidate = 1'b1; i_PC = 32'h1000;
      check("inv_pulse");
      cycle(); idle_inputs();
      for (int c = 0; c < ENTRIES; c++) begin
         i_PC = 32'h1000 + 32'(c * 4);
         i_Invalidate = (c == 5);
         if (c == 8) upd(32'h1020, 32'hABC, 2'b11); else i_WriteEnable = 1'b0;
         check("sweep_busy");
         cycle();
      end
      idle_inputs();
      for (int i = 0; i < ENTRIES; i++) begin
         i_PC = 32'h1000 + 32'(i * 4); check("post_sweep_miss");
      end

      upd(32'h2000, 32'h55, 2'b11); i_Invalidate = 1'b1; i_PC = 32'h2000;
      check("inv_wins_same_cycle");
      cycle(); idle_inputs();
      for (int c = 0; c < ENTRIES; c++) cycle();
      i_PC = 32'h2000; check("dropped_update_miss");

      for (int i = 0; i < ENTRIES; i++) begin
         upd(32'h3000 + 32'(i * 4), 32'h7000 + 32'(i), 2'b10); cycle();
      end
      idle_inputs();
      i_Invalidate = 1'b1; cycle(); idle_inputs();
      for (int c = 0; c < 6; c++) cycle();
      i_PC = 32'h3000; check("sweep_cycle7");
      rst_n = 1'b0; model_reset();
      check("reset_mid_sweep");
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < ENTRIES; i++) begin
         i_PC = 32'h3000 + 32'(i * 4); check("after_mid_reset_miss");
      end

      for (int n = 0; n < 400; n++) begin
         pc = {24'($urandom_range(0, 3)), 2'b00, 4'($urandom), 2'($urandom)};
         i_PC = ($urandom_range(0, 3) == 0) ? pc : {24'($urandom_range(0, 3)), 2'b00,
                                                    4'($urandom), 2'($urandom)};
         i_WriteEnable = 1'($urandom);
         i_UpdPC = pc; i_UpdTarget = $urandom; i_UpdCtrl = 2'($urandom);
         i_Invalidate = ($urandom_range(0, 39) == 0);
         check("random");
         cycle();
      end
      idle_inputs();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
